// File: rtl/tank_game_pkg.sv
// Shared definitions for the tank game: game-state encoding, bus sizing,
// hit-box geometry and the hit/damage state type.
package tank_game_pkg;

   localparam logic [2:0] GAME_PLAY   = 3'd2;
   localparam int         NUM_BULLETS = 5;
   localparam int         TANK_HALF   = 16;

   typedef enum logic [1:0] {
      ALIVE  = 2'd0,
      INVULN = 2'd1,
      DEAD   = 2'd2
   } hit_state_t;

   // One-axis box overlap. Both sides are sums, so there is never a
   // subtraction that could underflow when a bullet sits near coordinate 0.
   function automatic logic axis_overlap(input logic [9:0] bullet_c,
                                         input logic [9:0] tank_c,
                                         input logic [9:0] bullet_half,
                                         input logic [9:0] tank_half);
      logic [10:0] bullet_reach;
      logic [10:0] tank_reach;
      bullet_reach = {1'b0, bullet_c} + {1'b0, bullet_half} + {1'b0, tank_half};
      tank_reach   = {1'b0, tank_c} + {1'b0, tank_half} + {1'b0, bullet_half};
      return (bullet_reach > {1'b0, tank_c}) && (tank_reach > {1'b0, bullet_c});
   endfunction

endpackage

// File: rtl/bullet_slot_tracker.sv
// Per-slot bookkeeping for one bullet on the bus: how long it has been
// active (spawn guard), whether a kill is already outstanding for it, and
// whether it currently overlaps the tank hit box.
module bullet_slot_tracker #(
   parameter int TANK_HALF   = tank_game_pkg::TANK_HALF,
   parameter int SPAWN_GUARD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       active,
   input  logic [9:0] bullet_x,
   input  logic [9:0] bullet_y,
   input  logic [9:0] bullet_s,
   input  logic [9:0] tank_x,
   input  logic [9:0] tank_y,
   input  logic       kill_set,
   output logic       eligible_overlap
);
   import tank_game_pkg::*;

   localparam int                AGE_W     = $clog2(SPAWN_GUARD + 1);
   localparam logic [AGE_W-1:0]  GUARD_AGE = AGE_W'(SPAWN_GUARD);
   localparam logic [9:0]        HALF_10   = 10'(TANK_HALF);

   logic [AGE_W-1:0] age_q, age_d;
   logic             pending_q, pending_d;
   logic             overlap_x, overlap_y;

   // Age saturates at the guard value; pending latches on our own kill and
   // drops as soon as the owner retires the slot.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      age_d     = age_q;
      pending_d = pending_q;
      if (!active) begin
         age_d     = '0;
         pending_d = 1'b0;
      end else begin
         if (age_q < GUARD_AGE) begin
            age_d = age_q + 1'b1;
         end
         if (kill_set) begin
            pending_d = 1'b1;
         end
      end
   end

   // Slot state registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         age_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         age_q     <= age_d;
         pending_q <= pending_d;
      end
   end

   assign overlap_x = axis_overlap(bullet_x, tank_x, bullet_s, HALF_10);
   assign overlap_y = axis_overlap(bullet_y, tank_y, bullet_s, HALF_10);

   assign eligible_overlap = active && (age_q == GUARD_AGE) && !pending_q
                             && overlap_x && overlap_y;

endmodule

// File: rtl/tank_hit_monitor.sv
// Decides whether one tank is hit by bullets from one bullet source and
// runs the tank's damage / invulnerability / death state machine.
module tank_hit_monitor #(
   parameter int NUM_BULLETS   = tank_game_pkg::NUM_BULLETS,
   parameter int TANK_HALF     = tank_game_pkg::TANK_HALF,
   parameter int MAX_HEALTH    = 3,
   parameter int SPAWN_GUARD   = 4,
   parameter int INVULN_FRAMES = 60
) (
   input  logic                        frame_clk,
   input  logic                        Reset,
   input  logic [2:0]                  game_state,
   input  logic [9:0]                  TankX,
   input  logic [9:0]                  TankY,
   input  logic [NUM_BULLETS-1:0][9:0] BulletX,
   input  logic [NUM_BULLETS-1:0][9:0] BulletY,
   input  logic [NUM_BULLETS-1:0]      Is_bullet_active,
   input  logic [9:0]                  BulletS,
   output logic [NUM_BULLETS-1:0]      bullet_kill,
   output logic                        TankHit,
   output logic [1:0]                  TankHealth,
   output logic                        TankDead,
   output logic                        TankInvuln
);
   import tank_game_pkg::*;

   localparam int            TIMER_W     = $clog2(INVULN_FRAMES + 1);
   localparam logic [TIMER_W-1:0] INV_LOAD = TIMER_W'(INVULN_FRAMES);
   localparam logic [1:0]    FULL_HEALTH = 2'(MAX_HEALTH);

   hit_state_t               state_q, state_d;
   logic [1:0]               health_q, health_d;
   logic [TIMER_W-1:0]       timer_q, timer_d;
   logic [NUM_BULLETS-1:0]   kill_q, kill_d;
   logic                     hit_q, hit_d;
   logic [NUM_BULLETS-1:0]   elig_ov;

   for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
      bullet_slot_tracker #(
         .TANK_HALF  (TANK_HALF),
         .SPAWN_GUARD(SPAWN_GUARD)
      ) u_tracker (
         .clk             (frame_clk),
         .rst             (Reset),
         .active          (Is_bullet_active[i]),
         .bullet_x        (BulletX[i]),
         .bullet_y        (BulletY[i]),
         .bullet_s        (BulletS),
         .tank_x          (TankX),
         .tank_y          (TankY),
         .kill_set        (kill_d[i]),
         .eligible_overlap(elig_ov[i])
      );
   end

   // Next-state logic: damage in ALIVE, kill-only during INVULN, nothing in
   // DEAD; leaving play restores a fresh tank.
   always_comb begin
      state_d  = state_q;
      health_d = health_q;
      timer_d  = timer_q;
      kill_d   = '0;
      hit_d    = 1'b0;
      if (game_state != GAME_PLAY) begin
         state_d  = ALIVE;
         health_d = FULL_HEALTH;
         timer_d  = '0;
      end else begin
         case (state_q)
            ALIVE: begin
               if (|elig_ov) begin
                  kill_d   = elig_ov;
                  hit_d    = 1'b1;
                  health_d = health_q - 2'd1;
                  if (health_q == 2'd1) begin
                     state_d = DEAD;
                  end else begin
                     state_d = INVULN;
                     timer_d = INV_LOAD;
                  end
               end
            end
            INVULN: begin
               kill_d = elig_ov;
               if (timer_q <= TIMER_W'(1)) begin
                  timer_d = '0;
                  state_d = ALIVE;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            DEAD: begin
               state_d = DEAD;
            end
            default: begin
               state_d = ALIVE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= ALIVE;
         health_q <= FULL_HEALTH;
         timer_q  <= '0;
         kill_q   <= '0;
         hit_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         health_q <= health_d;
         timer_q  <= timer_d;
         kill_q   <= kill_d;
         hit_q    <= hit_d;
      end
   end

   assign bullet_kill = kill_q;
   assign TankHit     = hit_q;
   assign TankHealth  = health_q;
   assign TankDead    = (state_q == DEAD);
   assign TankInvuln  = (state_q == INVULN);

endmodule

// File: tb/tb_tank_hit_monitor.sv
// Self-checking bench for tank_hit_monitor: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the rules.
module tb_tank_hit_monitor;

   localparam int NB    = 5;
   localparam int HALF  = 16;
   localparam int MAXH  = 3;
   localparam int GUARD = 4;
   localparam int INV   = 60;

   logic                 frame_clk = 1'b0;
   logic                 Reset;
   logic [2:0]           game_state;
   logic [9:0]           TankX, TankY, BulletS;
   logic [NB-1:0][9:0]   BulletX, BulletY;
   logic [NB-1:0]        Is_bullet_active;
   logic [NB-1:0]        bullet_kill;
   logic                 TankHit;
   logic [1:0]           TankHealth;
   logic                 TankDead;
   logic                 TankInvuln;

   always #5 frame_clk = ~frame_clk;

   tank_hit_monitor #(
      .NUM_BULLETS  (NB),
      .TANK_HALF    (HALF),
      .MAX_HEALTH   (MAXH),
      .SPAWN_GUARD  (GUARD),
      .INVULN_FRAMES(INV)
   ) dut (
      .frame_clk       (frame_clk),
      .Reset           (Reset),
      .game_state      (game_state),
      .TankX           (TankX),
      .TankY           (TankY),
      .BulletX         (BulletX),
      .BulletY         (BulletY),
      .Is_bullet_active(Is_bullet_active),
      .BulletS         (BulletS),
      .bullet_kill     (bullet_kill),
      .TankHit         (TankHit),
      .TankHealth      (TankHealth),
      .TankDead        (TankDead),
      .TankInvuln      (TankInvuln)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: frames active per slot, outstanding-kill flags,
   // health count, frames of immunity left and a dead flag.
   int          m_age[NB];
   bit          m_pend[NB];
   int          m_health;
   int          m_inv_left;
   bit          m_dead;
   logic [NB-1:0] m_kill;
   bit          m_hit;

   function automatic bit near(input int b, input int t, input int s);
      return (b + s + HALF > t) && (t + HALF + s > b);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         m_age[i]  = 0;
         m_pend[i] = 0;
      end
      m_health   = MAXH;
      m_inv_left = 0;
      m_dead     = 0;
      m_kill     = '0;
      m_hit      = 0;
   endtask

   task automatic model_step();
      logic [NB-1:0] elig;
      for (int i = 0; i < NB; i++) begin
         elig[i] = Is_bullet_active[i] && (m_age[i] >= GUARD) && !m_pend[i]
                   && near(int'(BulletX[i]), int'(TankX), int'(BulletS))
                   && near(int'(BulletY[i]), int'(TankY), int'(BulletS));
      end
      m_kill = '0;
      m_hit  = 0;
      if (game_state != 3'd2) begin
         m_health   = MAXH;
         m_inv_left = 0;
         m_dead     = 0;
      end else if (m_dead) begin
         m_kill = '0;
      end else if (m_inv_left > 0) begin
         m_kill = elig;
         m_inv_left--;
      end else if (elig != '0) begin
         m_kill = elig;
         m_hit  = 1;
         m_health--;
         if (m_health == 0) m_dead = 1;
         else               m_inv_left = INV;
      end
      for (int i = 0; i < NB; i++) begin
         if (!Is_bullet_active[i]) begin
            m_age[i]  = 0;
            m_pend[i] = 0;
         end else begin
            if (m_age[i] < GUARD) m_age[i]++;
            if (m_kill[i]) m_pend[i] = 1;
         end
      end
   endtask

   task automatic check_outputs(input string pfx);
      check({pfx, "_kill"},   32'(bullet_kill), 32'(m_kill));
      check({pfx, "_hit"},    32'(TankHit),     32'(m_hit));
      check({pfx, "_health"}, 32'(TankHealth),  32'(m_health));
      check({pfx, "_dead"},   32'(TankDead),    32'(m_dead));
      check({pfx, "_invuln"}, 32'(TankInvuln),  32'(m_inv_left > 0));
   endtask

   task automatic tick(input string pfx);
      @(posedge frame_clk);
      model_step();
      #1;
      check_outputs(pfx);
   endtask

   task automatic ticks(input string pfx, input int n);
      for (int k = 0; k < n; k++) tick(pfx);
   endtask

   task automatic do_reset(input string pfx);
      Reset = 1'b1;
      #1;
      model_reset();
      check_outputs(pfx);
      #2;
      Reset = 1'b0;
   endtask

   task automatic set_slot(input int i, input int x, input int y, input bit act);
      BulletX[i]          = 10'(x);
      BulletY[i]          = 10'(y);
      Is_bullet_active[i] = act;
   endtask

   task automatic clear_slots();
      for (int i = 0; i < NB; i++) set_slot(i, 0, 0, 0);
   endtask

   initial begin
      Reset      = 1'b1;
      game_state = 3'd2;
      TankX      = 10'd320;
      TankY      = 10'd240;
      BulletS    = 10'd4;
      clear_slots();
      #2;
      model_reset();
      check_outputs("reset");
      #1;
      Reset = 1'b0;

      // Spawn guard, then first hit on slot 0.
      set_slot(0, 330, 240, 1);
      ticks("guard", 4);
      tick("hit0");
      check("t1_kill",   32'(bullet_kill), 32'h01);
      check("t1_hit",    32'(TankHit),     32'h1);
      check("t1_health", 32'(TankHealth),  32'd2);
      check("t1_invuln", 32'(TankInvuln),  32'h1);

      // Owner holds the slot active; no re-kill while pending.
      ticks("hold", 3);
      check("t2_no_rekill", 32'(bullet_kill), 32'h0);
      set_slot(0, 330, 240, 0);
      tick("drop0");
      check("t2_health", 32'(TankHealth), 32'd2);

      // Kill during immunity without damage.
      set_slot(2, 320, 250, 1);
      ticks("inv_guard", 4);
      tick("inv_kill");
      check("t4_kill",   32'(bullet_kill), 32'h04);
      check("t4_hit",    32'(TankHit),     32'h0);
      check("t4_health", 32'(TankHealth),  32'd2);
      set_slot(2, 320, 250, 0);
      ticks("inv_wait", 60);
      check("t4_invuln_end", 32'(TankInvuln), 32'h0);

      // Two slots eligible in the same frame: one decrement.
      game_state = 3'd0;
      tick("leave");
      game_state = 3'd2;
      set_slot(1, 310, 235, 1);
      set_slot(3, 325, 248, 1);
      ticks("dual_guard", 4);
      tick("dual");
      check("t3_kill",   32'(bullet_kill), 32'h0A);
      check("t3_hit",    32'(TankHit),     32'h1);
      check("t3_health", 32'(TankHealth),  32'd2);
      clear_slots();
      tick("dual_drop");

      // Three hits to death, then restore by leaving play.
      game_state = 3'd0;
      tick("leave2");
      game_state = 3'd2;
      for (int h = 0; h < 3; h++) begin
         set_slot(4, 318, 244, 1);
         ticks("kill_seq", 5);
         set_slot(4, 318, 244, 0);
         tick("kill_drop");
         if (h < 2) ticks("kill_wait", 60);
      end
      check("t5_dead",   32'(TankDead),   32'h1);
      check("t5_health", 32'(TankHealth), 32'd0);
      set_slot(0, 320, 240, 1);
      ticks("dead_ovl", 6);
      check("t5_dead_nokill", 32'(bullet_kill), 32'h0);
      clear_slots();
      game_state = 3'd0;
      tick("revive");
      check("t5_revive_dead",   32'(TankDead),   32'h0);
      check("t5_revive_health", 32'(TankHealth), 32'd3);
      game_state = 3'd2;

      // Bullet at X=0 near a tank at X=10.
      TankX = 10'd10;
      set_slot(1, 0, 240, 1);
      ticks("edge0", 5);
      check("t6_zero_kill", 32'(bullet_kill), 32'h02);
      clear_slots();
      tick("edge0_drop");

      // Reset while immune.
      do_reset("mid_inv_rst");
      check("t6_rst_invuln", 32'(TankInvuln), 32'h0);
      check("t6_rst_health", 32'(TankHealth), 32'd3);

      // Just outside the hit box (distance 21 > 20), then the exact boundary.
      TankX = 10'd320;
      set_slot(0, 341, 240, 1);
      ticks("far", 6);
      check("t6_far_kill", 32'(bullet_kill), 32'h0);
      check("t6_far_hit",  32'(TankHit),     32'h0);
      set_slot(1, 340, 240, 1);
      set_slot(2, 339, 240, 1);
      ticks("bound", 6);
      clear_slots();
      tick("bound_drop");

      // Randomized traffic around the tank.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 250 == 0) begin
            TankX   = 10'($urandom_range(940, 50));
            TankY   = 10'($urandom_range(940, 50));
            BulletS = 10'($urandom_range(8, 0));
         end
         game_state = ($urandom_range(59) == 0) ? 3'($urandom_range(7)) : 3'd2;
         for (int i = 0; i < NB; i++) begin
            if (Is_bullet_active[i]) begin
               if ((bullet_kill[i] && $urandom_range(1) == 0) || $urandom_range(24) == 0) begin
                  Is_bullet_active[i] = 1'b0;
               end else begin
                  BulletX[i] = 10'(int'(BulletX[i]) + int'($urandom_range(4)) - 2);
                  BulletY[i] = 10'(int'(BulletY[i]) + int'($urandom_range(4)) - 2);
               end
            end else if ($urandom_range(7) == 0) begin
               set_slot(i, int'(TankX) + int'($urandom_range(60)) - 30,
                           int'(TankY) + int'($urandom_range(60)) - 30, 1);
            end
         end
         tick("rand");
         if ($urandom_range(399) == 0) do_reset("rand_rst");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
